state_report_ctrl: RTL and testbench
====================================

STATE_REPORT_CTRL -- requirements
Module: state_report_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 77: bytes per status frame; byte_index runs 0..FRAME_LEN-1.
REQ-002 Parameter PERIOD, default 50_000_000: clocks between periodic report requests.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 match_found  input  1  single-cycle pulse: cracker found a hash match; urgent request.
REQ-006 host_req  input  1  single-cycle pulse: host asked for status over the UART.
REQ-007 tx_ready  input  1  UART transmitter accepts a byte this cycle when high with tx_valid.
REQ-008 tx_valid  output  1  byte on the byte-source output is valid for the transmitter.
REQ-009 byte_index  output  7  index driven to the registered byte source (frame formatter).
REQ-010 snapshot  output  1  one-cycle pulse: capture coherent copies of password, hashes and current hash.
REQ-011 frame_urgent  output  1  high for a whole frame when that frame was started by match_found.
REQ-012 busy  output  1  high from the snapshot cycle through acceptance of the last byte.

Function
REQ-013 The FSM SHALL have states IDLE, SNAP, FETCH, SEND.
REQ-014 Pending flags match_p, host_p and period_p SHALL be sticky, set by their events in any state.
REQ-015 The period counter SHALL count 0..PERIOD-1 continuously, including while busy, and set period_p on the wrap cycle.
REQ-016 IDLE with any flag set -> SNAP; priority match_p > host_p > period_p.
REQ-017 On IDLE->SNAP, the granted flag and period_p SHALL clear; frame_urgent SHALL latch 1 if match_p was granted, else 0.
REQ-018 An event coincident with its own grant cycle SHALL be consumed by that grant; a lower-priority event in that cycle SHALL remain pending.
REQ-019 SNAP: snapshot=1 and byte_index=0 for exactly one cycle, then -> FETCH.
REQ-020 FETCH: one cycle with tx_valid=0, covering the byte source's one-cycle register latency, then -> SEND.
REQ-021 SEND: tx_valid=1; byte_index and tx_valid SHALL stay stable until tx_ready is sampled high.
REQ-022 SEND with tx_ready and byte_index<FRAME_LEN-1: byte_index increments -> FETCH.
REQ-023 SEND with tx_ready and byte_index=FRAME_LEN-1: byte_index goes to 0, busy and frame_urgent clear -> IDLE.
REQ-024 A pending flag SHALL start the next frame on the cycle after IDLE is re-entered, giving a minimum one-cycle gap between frames.
REQ-025 Frame latency: first tx_valid rises 3 cycles after the grant-cycle edge (IDLE->SNAP->FETCH->SEND).
REQ-026 Per-frame cost is 2*FRAME_LEN+1 cycles when tx_ready is held high.

Reset
REQ-027 While rst is high: state IDLE; tx_valid, snapshot, frame_urgent, busy=0; byte_index=0; period counter=0; all pending flags cleared.
REQ-028 rst asserted mid-frame SHALL abandon the frame with no further tx_valid; after release, operation restarts in IDLE.

Structure
REQ-029 The shared package SHALL hold the FSM state encoding, the default FRAME_LEN (77), and the frame header/footer byte constants used by the formatter.
REQ-030 The period counter SHALL be a sub-module, period_ticker (parameter PERIOD; outputs a one-cycle tick on wrap).

Verification
REQ-031 PERIOD=200, tx_ready=1, no events: first snapshot 201 cycles after reset release; frame of 77 valid bytes, indices 0..76 in order; busy for 155 cycles.
REQ-032 host_req and match_found in the same IDLE cycle: first frame has frame_urgent=1; second frame starts 1 cycle after the first ends, with frame_urgent=0.
REQ-033 tx_ready low for 10 cycles at index 40: tx_valid stays high and byte_index stays 40 throughout; index 41 follows acceptance.
REQ-034 match_found during index 20 of a periodic frame: the frame completes unchanged; the next frame has frame_urgent=1.
REQ-035 rst pulse at index 30: all outputs 0 within the reset cycle; no tx_valid until a new grant after release.
REQ-036 Period wrap during a busy frame: exactly one periodic frame follows, not two.

Source files
------------

// File: rtl/state_report_ctrl_pkg.sv
// Shared definitions for the status-report controller and its frame formatter.
package state_report_ctrl_pkg;

  localparam int unsigned IDX_W         = 7;
  localparam int unsigned FRAME_LEN_DEF = 77;

  // Fixed framing bytes emitted by the formatter around the status payload
  localparam logic [7:0] FRAME_HDR_SYNC = 8'hA5;
  localparam logic [7:0] FRAME_HDR_TYPE = 8'h53;
  localparam logic [7:0] FRAME_FTR_END  = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNAP  = 2'd1,
    ST_FETCH = 2'd2,
    ST_SEND  = 2'd3
  } state_e;

endpackage

// File: rtl/period_ticker.sv
// Free-running 0..PERIOD-1 counter; tick_c is high on the wrap cycle.
module period_ticker #(
  parameter int unsigned PERIOD = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_c
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_c = (cnt_q == CNT_LAST);
    cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/state_report_ctrl.sv
// Arbitrates report requests and walks the frame formatter byte by byte into the UART.
module state_report_ctrl
  import state_report_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter int unsigned PERIOD    = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             match_found,
  input  logic             host_req,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [IDX_W-1:0] byte_index,
  output logic             snapshot,
  output logic             frame_urgent,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic             match_p_q, match_p_d;
  logic             host_p_q, host_p_d;
  logic             period_p_q, period_p_d;
  logic [IDX_W-1:0] byte_index_q, byte_index_d;
  logic             frame_urgent_q, frame_urgent_d;
  logic             tx_valid_q, tx_valid_d;
  logic             snapshot_q, snapshot_d;
  logic             busy_q, busy_d;
  logic             tick_c;

  period_ticker #(.PERIOD(PERIOD)) u_ticker (
    .clk    (clk),
    .rst    (rst),
    .tick_c (tick_c)
  );

  // Next state; events accumulate in sticky flags, the grant consumes only what it serves
  always_comb begin
    state_d        = state_q;
    match_p_d      = match_p_q | match_found;
    host_p_d       = host_p_q | host_req;
    period_p_d     = period_p_q | tick_c;
    byte_index_d   = byte_index_q;
    frame_urgent_d = frame_urgent_q;

    case (state_q)
      ST_IDLE: begin
        if (match_p_q || host_p_q || period_p_q) begin
          state_d      = ST_SNAP;
          byte_index_d = '0;
          if (match_p_q) begin
            match_p_d      = 1'b0;
            period_p_d     = tick_c;
            frame_urgent_d = 1'b1;
          end else if (host_p_q) begin
            host_p_d       = 1'b0;
            period_p_d     = tick_c;
            frame_urgent_d = 1'b0;
          end else begin
            period_p_d     = 1'b0;
            frame_urgent_d = 1'b0;
          end
        end
      end
      ST_SNAP:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_SEND;
      ST_SEND: begin
        if (tx_ready) begin
          if (byte_index_q == LAST_IDX) begin
            state_d        = ST_IDLE;
            byte_index_d   = '0;
            frame_urgent_d = 1'b0;
          end else begin
            state_d      = ST_FETCH;
            byte_index_d = byte_index_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tx_valid_d = (state_d == ST_SEND);
    snapshot_d = (state_d == ST_SNAP);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      match_p_q      <= 1'b0;
      host_p_q       <= 1'b0;
      period_p_q     <= 1'b0;
      byte_index_q   <= '0;
      frame_urgent_q <= 1'b0;
      tx_valid_q     <= 1'b0;
      snapshot_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      match_p_q      <= match_p_d;
      host_p_q       <= host_p_d;
      period_p_q     <= period_p_d;
      byte_index_q   <= byte_index_d;
      frame_urgent_q <= frame_urgent_d;
      tx_valid_q     <= tx_valid_d;
      snapshot_q     <= snapshot_d;
      busy_q         <= busy_d;
    end
  end

  assign tx_valid     = tx_valid_q;
  assign byte_index   = byte_index_q;
  assign snapshot     = snapshot_q;
  assign frame_urgent = frame_urgent_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_state_report_ctrl.sv
// Directed bench for state_report_ctrl with a short report period.
module tb_state_report_ctrl;

  localparam int unsigned FRAME_LEN = 77;
  localparam int unsigned PERIOD    = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       match_found = 1'b0;
  logic       host_req = 1'b0;
  logic       tx_ready = 1'b1;
  logic       tx_valid;
  logic [6:0] byte_index;
  logic       snapshot;
  logic       frame_urgent;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int edges = 0;

  state_report_ctrl #(.FRAME_LEN(FRAME_LEN), .PERIOD(PERIOD)) dut (
    .clk          (clk),
    .rst          (rst),
    .match_found  (match_found),
    .host_req     (host_req),
    .tx_ready     (tx_ready),
    .tx_valid     (tx_valid),
    .byte_index   (byte_index),
    .snapshot     (snapshot),
    .frame_urgent (frame_urgent),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic do_reset(output int rel);
    rst = 1'b1; match_found = 1'b0; host_req = 1'b0; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel = edges;
  endtask

  task automatic pulse_host();
    host_req = 1'b1;
    @(negedge clk);
    host_req = 1'b0;
  endtask

  task automatic wait_snapshot(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (snapshot) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_index(input int idx, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (tx_valid && int'(byte_index) == idx) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Walks one frame from its snapshot cycle to the first idle cycle; optionally fires match_found at a byte
  task automatic capture_frame(input int inject_idx, output int nbytes, output int busy_cyc,
                               output bit order_ok, output bit urgent, output int snap_edge,
                               output int first_valid_edge, output int end_edge, output bit timeout);
    bit injected = 1'b0;
    snap_edge = edges; urgent = frame_urgent; nbytes = 0; busy_cyc = 0; order_ok = 1'b1;
    first_valid_edge = -1; end_edge = -1; timeout = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) begin timeout = 1'b0; end_edge = edges; break; end
      busy_cyc++;
      if (tx_valid && first_valid_edge < 0) first_valid_edge = edges;
      if (tx_valid && inject_idx >= 0 && !injected && int'(byte_index) == inject_idx) begin
        match_found = 1'b1; injected = 1'b1;
      end else begin
        match_found = 1'b0;
      end
      if (tx_valid && tx_ready) begin
        if (int'(byte_index) != nbytes) order_ok = 1'b0;
        nbytes++;
      end
      @(negedge clk);
    end
    match_found = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; host_req = 1'b1; match_found = 1'b1;
    repeat (3) @(negedge clk);
    host_req = 1'b0; match_found = 1'b0;
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    tests++; if (snapshot !== 1'b0) begin fails++; $display("FAIL reset_snapshot: got %b expected 0", snapshot); end
    tests++; if (frame_urgent !== 1'b0) begin fails++; $display("FAIL reset_urgent: got %b expected 0", frame_urgent); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (byte_index !== 7'd0) begin fails++; $display("FAIL reset_index: got %0d expected 0", byte_index); end
  endtask

  task automatic test_periodic();
    int rel, nb, bc, se, fv, ee; bit ok, ord, urg, to;
    do_reset(rel);
    wait_snapshot(400, ok);
    tests++; if (!ok || edges - rel != 201) begin fails++; $display("FAIL periodic_first_snap: got %0d expected 201", edges - rel); end
    capture_frame(-1, nb, bc, ord, urg, se, fv, ee, to);
    tests++; if (to) begin fails++; $display("FAIL periodic_timeout: got 1 expected 0"); end
    tests++; if (nb != 77) begin fails++; $display("FAIL periodic_bytes: got %0d expected 77", nb); end
    tests++; if (!ord) begin fails++; $display("FAIL periodic_order: got 0 expected 1"); end
    tests++; if (bc != 155) begin fails++; $display("FAIL periodic_busy: got %0d expected 155", bc); end
    tests++; if (urg !== 1'b0) begin fails++; $display("FAIL periodic_urgent: got %b expected 0", urg); end
    tests++; if (fv - se != 2) begin fails++; $display("FAIL periodic_latency: got %0d expected 2", fv - se); end
  endtask

  task automatic test_priority();
    int rel, nb, bc, se, fv, ee, se1, ee1; bit ok, ord, urg1, urg2, to;
    do_reset(rel);
    repeat (5) @(negedge clk);
    host_req = 1'b1; match_found = 1'b1;
    @(negedge clk);
    host_req = 1'b0; match_found = 1'b0;
    wait_snapshot(50, ok);
    tests++; if (!ok || edges - rel != 7) begin fails++; $display("FAIL prio_grant_time: got %0d expected 7", edges - rel); end
    capture_frame(-1, nb, bc, ord, urg1, se1, fv, ee1, to);
    tests++; if (urg1 !== 1'b1) begin fails++; $display("FAIL prio_first_urgent: got %b expected 1", urg1); end
    wait_snapshot(10, ok);
    tests++; if (!ok || edges != ee1 + 1) begin fails++; $display("FAIL prio_gap: got %0d expected %0d", edges, ee1 + 1); end
    capture_frame(-1, nb, bc, ord, urg2, se, fv, ee, to);
    tests++; if (urg2 !== 1'b0) begin fails++; $display("FAIL prio_second_urgent: got %b expected 0", urg2); end
    tests++; if (nb != 77 || !ord) begin fails++; $display("FAIL prio_second_bytes: got %0d expected 77", nb); end
  endtask

  task automatic test_backpressure();
    int rel, bad; bit ok;
    do_reset(rel);
    pulse_host();
    wait_index(40, 400, ok);
    tests++; if (!ok) begin fails++; $display("FAIL bp_reach40: got 0 expected 1"); end
    tx_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || byte_index !== 7'd40) bad++;
    end
    tx_ready = 1'b1;
    tests++; if (bad != 0) begin fails++; $display("FAIL bp_stall_stable: got %0d bad cycles expected 0", bad); end
    @(negedge clk);
    tests++; if (tx_valid !== 1'b0 || byte_index !== 7'd41) begin fails++; $display("FAIL bp_fetch41: got valid=%b idx=%0d expected valid=0 idx=41", tx_valid, byte_index); end
    @(negedge clk);
    tests++; if (tx_valid !== 1'b1 || byte_index !== 7'd41) begin fails++; $display("FAIL bp_send41: got valid=%b idx=%0d expected valid=1 idx=41", tx_valid, byte_index); end
  endtask

  task automatic test_match_midframe();
    int rel, nb, bc, se, fv, ee; bit ok, ord, urg, to;
    do_reset(rel);
    wait_snapshot(400, ok);
    capture_frame(20, nb, bc, ord, urg, se, fv, ee, to);
    tests++; if (nb != 77 || !ord || bc != 155) begin fails++; $display("FAIL mid_frame_intact: got bytes=%0d busy=%0d expected 77 155", nb, bc); end
    tests++; if (urg !== 1'b0) begin fails++; $display("FAIL mid_frame_urgent: got %b expected 0", urg); end
    wait_snapshot(10, ok);
    tests++; if (!ok || edges != ee + 1) begin fails++; $display("FAIL mid_next_start: got %0d expected %0d", edges, ee + 1); end
    tests++; if (frame_urgent !== 1'b1) begin fails++; $display("FAIL mid_next_urgent: got %b expected 1", frame_urgent); end
  endtask

  task automatic test_reset_midframe();
    int rel, act; bit ok;
    do_reset(rel);
    pulse_host();
    wait_index(30, 400, ok);
    rst = 1'b1;
    #1;
    tests++; if ({tx_valid, snapshot, frame_urgent, busy, byte_index} !== 11'd0) begin fails++; $display("FAIL rst_mid_outputs: got %b expected 0", {tx_valid, snapshot, frame_urgent, busy, byte_index}); end
    @(negedge clk);
    rst = 1'b0;
    rel = edges;
    act = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx_valid || snapshot || busy) act++;
    end
    tests++; if (act != 0) begin fails++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", act); end
    wait_snapshot(100, ok);
    tests++; if (!ok || edges - rel != 201) begin fails++; $display("FAIL rst_mid_restart: got %0d expected 201", edges - rel); end
  endtask

  task automatic test_period_during_busy();
    int rel, nb, bc, se, fv, ee, extra; bit ok, ord, urg, to;
    do_reset(rel);
    repeat (59) @(negedge clk);
    pulse_host();
    wait_snapshot(20, ok);
    tests++; if (!ok || edges - rel != 61) begin fails++; $display("FAIL pwrap_host_start: got %0d expected 61", edges - rel); end
    capture_frame(-1, nb, bc, ord, urg, se, fv, ee, to);
    wait_snapshot(10, ok);
    tests++; if (!ok || edges != ee + 1) begin fails++; $display("FAIL pwrap_periodic_start: got %0d expected %0d", edges, ee + 1); end
    capture_frame(-1, nb, bc, ord, urg, se, fv, ee, to);
    tests++; if (nb != 77 || urg !== 1'b0) begin fails++; $display("FAIL pwrap_periodic_frame: got bytes=%0d urgent=%b expected 77 0", nb, urg); end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (snapshot || busy) extra++;
      @(negedge clk);
    end
    tests++; if (extra != 0) begin fails++; $display("FAIL pwrap_single: got %0d extra busy cycles expected 0", extra); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_periodic();
    test_priority();
    test_backpressure();
    test_match_midframe();
    test_reset_midframe();
    test_period_during_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
